march_c_controller: RTL and testbench
=====================================

// Module: march_c_controller
// PURPOSE
//  BIST sequencer running March C- over ARRAY_SIZE words:
//  {B(w0); U(r0,w1); U(r1,w0); D(r0,w1); D(r1,w0); B(r0)}, where U is ascending, D descending, B either.
//  Sits upstream of the address generator: drives its en/rst and consumes its count.
//  Drives memory-under-test control, compares read data and reports pass/fail.
// PARAMETERS
//  ARRAY_SIZE  16                   words under test, >=2, power of two not required
//  ADDR_WIDTH  $clog2(ARRAY_SIZE)   address width
//  DATA_WIDTH  8                    memory word width; patterns are all-0 or all-1
// PORTS
//  clk           in   1           clock, all flops on rising edge
//  rst_n         in   1           asynchronous active-low reset
//  start         in   1           level; sampled in IDLE/DONE to launch a run
//  addr_in       in   ADDR_WIDTH  current count from the address generator
//  addr_gen_en   out  1           advance the address generator
//  addr_gen_rst  out  1           synchronous clear of the address generator
//  mem_addr      out  ADDR_WIDTH  memory address: addr_in (U/B) or ARRAY_SIZE-1-addr_in (D)
//  mem_we        out  1           write strobe
//  mem_re        out  1           read strobe; memory returns data 1 cycle later
//  mem_wdata     out  DATA_WIDTH  {DATA_WIDTH{pattern bit}}
//  mem_rdata     in   DATA_WIDTH  read data, valid the cycle after mem_re
//  busy          out  1           run in progress
//  done          out  1           run finished, result valid
//  pass          out  1           done && no mismatch seen
//  fail_addr     out  ADDR_WIDTH  address of first mismatch (FAIL_LOG_EN)
//  fail_elem     out  3           March element 1..5 of first mismatch (FAIL_LOG_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, pass=0, fail flag=0, compare pipe cleared, fail_addr=0, fail_elem=0.
//  - States: IDLE, M0..M5, DRAIN, DONE. Op index op (0/1) within M1..M4. M0 and M5 have one op.
//  - IDLE: addr_gen_rst=1, no memory strobes. start=1 -> M0, op=0. Sticky fail cleared. busy=1 from next cycle.
//  - Each M-state cycle issues exactly one op: M0 w0; M1 r0,w1; M2 r1,w0; M3 r0,w1; M4 r1,w0; M5 r0.
//  - Strobe and address outputs are combinational from state, op and addr_in. mem_we and mem_re are never both high.
//  - Last op of an element at an address, addr_in<ARRAY_SIZE-1: addr_gen_en=1, op->0.
//  - Last op at addr_in==ARRAY_SIZE-1: addr_gen_rst=1, addr_gen_en=0, next element.
//    Wrap never relies on counter overflow.
//  - Non-last op: addr_gen_en=0, op->1.
//  - M5 complete -> DRAIN (1 cycle, final compare) -> DONE.
//  - Run length: 10*ARRAY_SIZE op cycles + 1 DRAIN cycle.
//  - Compare: on mem_re, register exp bit, mem_addr and element id.
//    Next cycle, mem_rdata != {DATA_WIDTH{exp}} sets the sticky fail flag.
//  - DONE: busy=0, done=1, pass=~fail. Holds while start=0. start=1 in DONE -> M0, done=0, fail cleared.
//  - start while busy: ignored.
//  - rst_n low mid-run: immediate return to reset values.
//    IDLE then holds addr_gen_rst=1, so the generator clears on the next clk.
//  - Back-to-back mismatches: only the first is logged; fail stays set.
// CONFIGURATION
//  FAIL_LOG_EN defined: fail_addr/fail_elem capture the first mismatch of a run.
//    Held until the next launch; cleared at launch and on reset.
//  FAIL_LOG_EN undefined: capture logic is absent; fail_addr and fail_elem are tied to 0.
//  pass/fail behaviour is identical in both builds.
// TESTING
//  1. Fault-free memory model, ARRAY_SIZE=16, start pulse -> busy for 161 cycles, done=1, pass=1.
//     addr_gen_rst asserted exactly 5 times during the run.
//  2. Address trace -> M0-M2 and M5 give mem_addr 0..15; M3/M4 give 15..0.
//     Each address is read-then-written within an element.
//  3. Stuck-at-1 at word 5 bit 0 -> first mismatch in M1 (r0), done=1, pass=0.
//     FAIL_LOG_EN: fail_addr=5, fail_elem=1.
//  4. rst_n low at cycle 40 of a run -> busy=0 and done=0 immediately.
//     Next start gives a full 161-cycle run with pass=1.
//  5. ARRAY_SIZE=12 -> 121-cycle run, mem_addr never >11, pass=1.
//  6. In DONE after a fail, start=1 -> fail cleared, fault-free rerun -> pass=1.
//     FAIL_LOG_EN: fail_addr=0, fail_elem=0.

Source files
------------

// File: rtl/march_c_controller.sv
`default_nettype none
// ============================================================================
// Module      : march_c_controller
// Description : March C- BIST sequencer over ARRAY_SIZE memory words.
//               Runs {B(w0); U(r0,w1); U(r1,w0); D(r0,w1); D(r1,w0); B(r0)}.
//               Steers an external address generator (addr_gen_en and
//               addr_gen_rst) and consumes its count on addr_in. Drives the
//               memory-under-test strobes, checks read data one cycle after
//               each read and reports pass/fail when the run ends.
// Optional    : `define FAIL_LOG_EN to keep the address and element of the
//               first mismatch on fail_addr/fail_elem. Without it both
//               outputs are tied to zero. pass/fail behaves the same either way.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               start        - launch request, sampled in IDLE and DONE
//               addr_in      - count from the address generator
//               addr_gen_en  - advance the address generator
//               addr_gen_rst - synchronous clear of the address generator
//               mem_addr     - memory address (reversed in the D elements)
//               mem_we       - write strobe
//               mem_re       - read strobe, data returns one cycle later
//               mem_wdata    - write data, all-0 or all-1 pattern
//               mem_rdata    - read data, valid the cycle after mem_re
//               busy         - run in progress
//               done         - run finished, result valid
//               pass         - done and no mismatch seen
//               fail_addr    - address of the first mismatch
//               fail_elem    - March element (1..5) of the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module march_c_controller #(
    parameter int ARRAY_SIZE = 16,
    parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE),
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  addr_gen_en,
    output logic                  addr_gen_rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem
);

    // March elements are encoded consecutively so that "next element" is a
    // plain increment, and element number = encoding - 1 for M1..M5.
    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_m0    = 4'd1;
    localparam logic [3:0] c_st_m1    = 4'd2;
    localparam logic [3:0] c_st_m2    = 4'd3;
    localparam logic [3:0] c_st_m3    = 4'd4;
    localparam logic [3:0] c_st_m4    = 4'd5;
    localparam logic [3:0] c_st_m5    = 4'd6;
    localparam logic [3:0] c_st_drain = 4'd7;
    localparam logic [3:0] c_st_done  = 4'd8;

    localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(ARRAY_SIZE - 1);

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    logic       r_op;
    logic       w_op_nxt;
    logic       w_launch;
    logic       w_mstate;
    logic       w_last_op;
    logic       w_desc;
    logic       w_bit;
    logic       r_cmp_valid;
    logic       r_cmp_exp;
    logic       r_fail;
    logic       w_mismatch;

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_launch     = 1'b0;
        w_mstate     = 1'b0;
        w_last_op    = 1'b0;
        w_desc       = 1'b0;
        w_bit        = 1'b0;
        addr_gen_en  = 1'b0;
        addr_gen_rst = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;

        case (r_state)
            c_st_idle, c_st_done: begin
                // Keep the generator cleared so a launch always starts at 0.
                addr_gen_rst = 1'b1;
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = c_st_m0;
                    w_op_nxt    = 1'b0;
                end
            end
            c_st_m0: begin
                w_mstate  = 1'b1;
                w_last_op = 1'b1;
                mem_we    = 1'b1;
                w_bit     = 1'b0;
            end
            c_st_m1, c_st_m3: begin
                // op0 reads 0, op1 writes 1
                w_mstate  = 1'b1;
                w_desc    = (r_state == c_st_m3);
                w_last_op = r_op;
                mem_re    = ~r_op;
                mem_we    = r_op;
                w_bit     = r_op;
            end
            c_st_m2, c_st_m4: begin
                // op0 reads 1, op1 writes 0
                w_mstate  = 1'b1;
                w_desc    = (r_state == c_st_m4);
                w_last_op = r_op;
                mem_re    = ~r_op;
                mem_we    = r_op;
                w_bit     = ~r_op;
            end
            c_st_m5: begin
                w_mstate  = 1'b1;
                w_last_op = 1'b1;
                mem_re    = 1'b1;
                w_bit     = 1'b0;
            end
            c_st_drain: begin
                // Last read's data is compared this cycle.
                w_state_nxt = c_st_done;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        if (w_mstate) begin
            if (!w_last_op) begin
                w_op_nxt = 1'b1;
            end else begin
                w_op_nxt = 1'b0;
                if (addr_in != c_last) begin
                    addr_gen_en = 1'b1;
                end else begin
                    // Element boundary: wrap by explicit clear, never by
                    // counter overflow. After M5 the counter is simply parked;
                    // DONE clears it before any relaunch.
                    w_state_nxt  = r_state + 4'd1;
                    addr_gen_rst = (r_state != c_st_m5);
                end
            end
        end
    end

    assign mem_addr  = w_desc ? (c_last - addr_in) : addr_in;
    assign mem_wdata = mem_we ? {DATA_WIDTH{w_bit}} : '0;

    assign busy = (r_state != c_st_idle) && (r_state != c_st_done);
    assign done = (r_state == c_st_done);
    assign pass = done && !r_fail;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_op    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read compare: expectation captured with the read strobe, checked
    // against the data that returns on the following cycle.
    // ------------------------------------------------------------------
    assign w_mismatch = r_cmp_valid && (mem_rdata != {DATA_WIDTH{r_cmp_exp}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_cmp_valid <= mem_re;
            if (mem_re) begin
                r_cmp_exp <= w_bit;
            end
            if (w_launch) begin
                r_fail <= 1'b0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
            end
        end
    end

`ifdef FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [2:0]            r_cmp_elem;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_elem;
    logic [2:0]            w_elem;

    // Element number of the current read (only meaningful in M1..M5).
    assign w_elem = r_state[2:0] - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_addr  <= '0;
            r_cmp_elem  <= 3'd0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else begin
            if (mem_re) begin
                r_cmp_addr <= mem_addr;
                r_cmp_elem <= w_elem;
            end
            if (w_launch) begin
                r_fail_addr <= '0;
                r_fail_elem <= 3'd0;
            end else if (w_mismatch && !r_fail) begin
                // Only the first mismatch of a run is kept.
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
            end
        end
    end

    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;
`else
    assign fail_addr = '0;
    assign fail_elem = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_march_c_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_march_c_controller
// Description : Self-checking bench for march_c_controller. Two instances
//               (16 and 12 words) each with a behavioural address generator
//               and memory that can carry one stuck-at bit. Expected traces
//               and results come from an algorithmic March C- model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_march_c_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] start;
    wire  [1:0] agen_en, agen_rst, mem_we, mem_re, busy, done, pass;
    wire  [1:0][3:0] mem_addr, fail_addr;
    wire  [1:0][7:0] mem_wdata;
    wire  [1:0][2:0] fail_elem;

    int   sel;
    logic fault_on;
    int   fault_addr;
    int   fault_bit;
    logic fault_val;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int N = (g == 0) ? 16 : 12;
        logic [3:0] cnt;
        logic [7:0] mem [16];
        logic [7:0] rdata;

        always @(posedge clk) begin
            if (agen_rst[g])     cnt <= 4'd0;
            else if (agen_en[g]) cnt <= cnt + 4'd1;
            if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
            if (mem_re[g]) begin
                rdata <= mem[mem_addr[g]];
                if (fault_on && sel == g && int'(mem_addr[g]) == fault_addr)
                    rdata[fault_bit] <= fault_val;
            end
        end

        march_c_controller #(.ARRAY_SIZE(N), .DATA_WIDTH(8)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start[g]),
            .addr_in      (cnt),
            .addr_gen_en  (agen_en[g]),
            .addr_gen_rst (agen_rst[g]),
            .mem_addr     (mem_addr[g]),
            .mem_we       (mem_we[g]),
            .mem_re       (mem_re[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (rdata),
            .busy         (busy[g]),
            .done         (done[g]),
            .pass         (pass[g]),
            .fail_addr    (fail_addr[g]),
            .fail_elem    (fail_elem[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle vector: {busy, done, pass, we, re, addr, wdata}
    logic [16:0] exp_q[$];
    logic        m_pass;
    int          m_addr;
    int          m_elem;

    // Walks the March C- algorithm over an ideal array with the fault applied
    // on reads, producing the op sequence and the first detected mismatch.
    function automatic void model_run(input int n);
        logic [7:0] m [16];
        int rdv[6];
        int wrv[6];
        int a;
        logic [7:0] v;
        rdv = '{-1, 0, 1, 0, 1, 0};
        wrv = '{0, 1, 0, 1, 0, -1};
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        exp_q.delete();
        m_pass = 1'b1; m_addr = 0; m_elem = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a = (e == 3 || e == 4) ? n - 1 - k : k;
                if (rdv[e] >= 0) begin
                    v = m[a];
                    if (fault_on && a == fault_addr) v[fault_bit] = fault_val;
                    exp_q.push_back({3'b100, 2'b01, 4'(a), 8'h00});
                    if (v !== {8{rdv[e][0]}} && m_pass) begin
                        m_pass = 1'b0; m_addr = a; m_elem = e;
                    end
                end
                if (wrv[e] >= 0) begin
                    m[a] = {8{wrv[e][0]}};
                    exp_q.push_back({3'b100, 2'b10, 4'(a), {8{wrv[e][0]}}});
                end
            end
        end
        exp_q.push_back({3'b100, 2'b00, 4'd0, 8'h00});  // drain cycle
    endfunction

    task automatic do_run(input int s, input logic f_on, input int f_addr,
                          input int f_bit, input logic f_val, input logic poke);
        int n;
        int rc;
        logic [16:0] obs;
        n = (s == 0) ? 16 : 12;
        sel = s; fault_on = f_on; fault_addr = f_addr; fault_bit = f_bit; fault_val = f_val;
        model_run(n);
        rc = 0;
        @(negedge clk) start[s] = 1'b1;
        @(negedge clk) start[s] = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = {busy[s], done[s], pass[s], mem_we[s], mem_re[s],
                   (mem_we[s] | mem_re[s]) ? mem_addr[s] : 4'd0,
                   mem_we[s] ? mem_wdata[s] : 8'h00};
            check($sformatf("trace n%0d c%0d", n, i), 64'(obs), 64'(exp_q[i]));
            if (busy[s] && agen_rst[s]) rc++;
            start[s] = (poke && i == 20);  // start while busy must be ignored
            @(negedge clk);
        end
        start[s] = 1'b0;
        check($sformatf("end busy n%0d", n), 64'(busy[s]), 64'd0);
        check($sformatf("end done n%0d", n), 64'(done[s]), 64'd1);
        check($sformatf("end pass n%0d", n), 64'(pass[s]), 64'(m_pass));
        check($sformatf("gen clears n%0d", n), 64'(rc), 64'd5);
`ifdef FAIL_LOG_EN
        check("fail_addr", 64'(fail_addr[s]), m_pass ? 64'd0 : 64'(m_addr));
        check("fail_elem", 64'(fail_elem[s]), m_pass ? 64'd0 : 64'(m_elem));
`else
        check("fail_addr", 64'(fail_addr[s]), 64'd0);
        check("fail_elem", 64'(fail_elem[s]), 64'd0);
`endif
    endtask

    initial begin
        int rs, rn;
        rst_n = 1'b0; start = 2'b00; sel = 0;
        fault_on = 1'b0; fault_addr = 0; fault_bit = 0; fault_val = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset busy %0d", g), 64'(busy[g]), 64'd0);
            check($sformatf("reset done %0d", g), 64'(done[g]), 64'd0);
            check($sformatf("reset pass %0d", g), 64'(pass[g]), 64'd0);
            check($sformatf("reset faddr %0d", g), 64'(fail_addr[g]), 64'd0);
            check($sformatf("reset felem %0d", g), 64'(fail_elem[g]), 64'd0);
            check($sformatf("reset strobes %0d", g), 64'({mem_we[g], mem_re[g], agen_rst[g]}), 64'b001);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free full run, with a start pulse in the middle of it
        do_run(0, 1'b0, 0, 0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("done hold", 64'({done[0], pass[0], busy[0]}), 64'b110);

        // Stuck-at-1 at word 5 bit 0
        do_run(0, 1'b1, 5, 0, 1'b1, 1'b0);
        check("sa1 elem from model", 64'(m_elem), 64'd1);

        // Relaunch from DONE after a fail, fault-free
        do_run(0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a run
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (39) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy[0]), 64'd0);
        check("midreset done", 64'(done[0]), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_run(0, 1'b0, 0, 0, 1'b0, 1'b0);

        // 12-word instance
        do_run(1, 1'b0, 0, 0, 1'b0, 1'b0);
        do_run(1, 1'b1, 11, 7, 1'b0, 1'b0);

        // Randomized faults across both instances
        for (int t = 0; t < 6; t++) begin
            rs = int'($urandom_range(1, 0));
            rn = (rs == 0) ? 16 : 12;
            do_run(rs, 1'($urandom_range(1, 0)), int'($urandom_range(rn - 1, 0)),
                   int'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
